filtro_iir_parametrizable: RTL and testbench

FILTRO_IIR_PARAMETRIZABLE -- requirements
Module: filtro_iir_parametrizable

---
 rtl/filtro_pkg.sv | 30 +++
 rtl/filtro_mac_sat.sv | 83 ++++++++
 rtl/filtro_iir_parametrizable.sv | 241 ++++++++++++++++++++++++
 tb/tb_filtro_iir_parametrizable.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/filtro_pkg.sv
// -----------------------------------------------------------------------------
// filtro_pkg
// Shared definitions for the multichannel biquad IIR filter:
//   - estado_t   : controller state encoding (REPOSO, MAC, SATURA)
//   - COEF_B0..COEF_A2 : coefficient bank addresses as seen on Coef_Addr
//   - NUM_COEF   : number of coefficients in the bank
//   - acc_width  : accumulator width for a given sample width
// -----------------------------------------------------------------------------
package filtro_pkg;

  typedef enum logic [1:0] {
    REPOSO = 2'd0,
    MAC    = 2'd1,
    SATURA = 2'd2
  } estado_t;

  localparam logic [2:0] COEF_B0 = 3'd0;
  localparam logic [2:0] COEF_B1 = 3'd1;
  localparam logic [2:0] COEF_B2 = 3'd2;
  localparam logic [2:0] COEF_A1 = 3'd3;
  localparam logic [2:0] COEF_A2 = 3'd4;

  localparam int NUM_COEF = 5;

  // Five N x N products need three guard bits above the 2N-bit product.
  function automatic int acc_width(input int n);
    return 2 * n + 3;
  endfunction

endpackage

// File: rtl/filtro_mac_sat.sv
// -----------------------------------------------------------------------------
// filtro_mac_sat
// Shared arithmetic datapath of the IIR filter: one signed N x N multiplier,
// a 2N+3 bit accumulator, and the output stage that rescales the sum by F
// fractional bits and clips it to the signed N-bit range.
//
// Ports:
//   clk       in   clock, rising edge
//   reset_n   in   synchronous active-low reset, clears the accumulator
//   clear     in   zero the accumulator (start of a new sample)
//   enable    in   add or subtract the current product this cycle
//   subtract  in   1 = subtract the product (feedback terms a1, a2)
//   coef      in   N-bit signed coefficient, F fractional bits
//   operand   in   N-bit signed sample (x or y history)
//   y_sat     out  N-bit signed rescaled and clipped accumulator
//   saturado  out  1 when y_sat had to be clipped
// -----------------------------------------------------------------------------
module filtro_mac_sat
  import filtro_pkg::*;
#(
  parameter int N = 25,
  parameter int F = 15
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clear,
  input  logic                enable,
  input  logic                subtract,
  input  logic signed [N-1:0] coef,
  input  logic signed [N-1:0] operand,
  output logic signed [N-1:0] y_sat,
  output logic                saturado
);

  localparam int AW = acc_width(N);

  // Clip limits sign-extended to the accumulator width so the comparison
  // happens on the full-precision shifted value.
  localparam logic signed [AW-1:0] LIM_MAX = {{(AW-N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [AW-1:0] LIM_MIN = {{(AW-N+1){1'b1}}, {(N-1){1'b0}}};

  logic signed [2*N-1:0] producto;
  logic signed [AW-1:0]  producto_ext;
  logic signed [AW-1:0]  acc;
  logic signed [AW-1:0]  desplazado;

  assign producto     = coef * operand;
  assign producto_ext = {{(AW-2*N){producto[2*N-1]}}, producto};

  // Accumulator: cleared when a sample is accepted, then one product per
  // enabled cycle; the feedback terms enter with a negative sign.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (enable) begin
      if (subtract) begin
        acc <= acc - producto_ext;
      end else begin
        acc <= acc + producto_ext;
      end
    end
  end

  // Arithmetic shift floors toward minus infinity, removing the coefficient
  // scaling before the result is squeezed back into N bits.
  assign desplazado = acc >>> F;

  // Clip to the representable N-bit range and flag when that happened.
  always_comb begin
    y_sat    = desplazado[N-1:0];
    saturado = 1'b0;
    if (desplazado > LIM_MAX) begin
      y_sat    = LIM_MAX[N-1:0];
      saturado = 1'b1;
    end else if (desplazado < LIM_MIN) begin
      y_sat    = LIM_MIN[N-1:0];
      saturado = 1'b1;
    end
  end

endmodule

// File: rtl/filtro_iir_parametrizable.sv
// -----------------------------------------------------------------------------
// filtro_iir_parametrizable
// Direct form I biquad IIR filter, time-shared between CANALES channels.
// Each accepted sample takes five MAC cycles (b0, b1, b2, a1, a2) plus one
// rescale/clip cycle; the result appears seven cycles after acceptance.
//
// Ports:
//   Clk            in   clock, rising edge
//   Reset_n        in   synchronous active-low reset
//   Uk             in   N-bit signed input sample
//   Canal_In       in   channel of Uk
//   Bandera_ADC    in   sample-valid strobe
//   Coef_We        in   coefficient write strobe
//   Coef_Addr      in   0=b0 1=b1 2=b2 3=a1 4=a2, others ignored
//   Coef_Data      in   N-bit signed coefficient, F fractional bits
//   Yk             out  N-bit signed filtered sample
//   Canal_Out      out  channel of Yk
//   Bandera_Listo  out  one-cycle pulse, Yk/Canal_Out/Saturado are new
//   Saturado       out  Yk was clipped
//   Ocupado        out  datapath busy, new strobes are dropped
// -----------------------------------------------------------------------------
module filtro_iir_parametrizable
  import filtro_pkg::*;
#(
  parameter  int N       = 25,
  parameter  int F       = 15,
  parameter  int CANALES = 2,
  localparam int CW      = (CANALES > 1) ? $clog2(CANALES) : 1
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic signed [N-1:0] Uk,
  input  logic [CW-1:0]       Canal_In,
  input  logic                Bandera_ADC,
  input  logic                Coef_We,
  input  logic [2:0]          Coef_Addr,
  input  logic signed [N-1:0] Coef_Data,
  output logic signed [N-1:0] Yk,
  output logic [CW-1:0]       Canal_Out,
  output logic                Bandera_Listo,
  output logic                Saturado,
  output logic                Ocupado
);

  localparam logic signed [N-1:0] COEF_UNO     = N'(1) << F;
  localparam logic [CW:0]         CANALES_EXT  = (CW+1)'(CANALES);
  localparam logic [2:0]          ULTIMO_PASO  = 3'd4;

  estado_t estado;
  estado_t estado_sig;

  logic [2:0]          paso;
  logic                acepta;
  logic                mac_en;
  logic                restar;
  logic signed [N-1:0] coef_sel;
  logic signed [N-1:0] operando;
  logic signed [N-1:0] y_sat;
  logic                sat;

  logic signed [N-1:0] coef [NUM_COEF];

  logic signed [N-1:0] x1_mem [CANALES];
  logic signed [N-1:0] x2_mem [CANALES];
  logic signed [N-1:0] y1_mem [CANALES];
  logic signed [N-1:0] y2_mem [CANALES];

  logic signed [N-1:0] x_cur;
  logic [CW-1:0]       canal_cur;

  // State register; any reset edge abandons a sample in flight.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      estado <= REPOSO;
    end else begin
      estado <= estado_sig;
    end
  end

  // Next state and control. Only REPOSO listens to Bandera_ADC, so strobes
  // arriving while busy vanish instead of queueing. The cycle in which
  // Bandera_Listo is high is already REPOSO, which lets samples run
  // back to back every seven cycles.
  always_comb begin
    estado_sig = estado;
    acepta     = 1'b0;
    mac_en     = 1'b0;
    Ocupado    = 1'b0;
    case (estado)
      REPOSO: begin
        if (Bandera_ADC && ({1'b0, Canal_In} < CANALES_EXT)) begin
          acepta     = 1'b1;
          estado_sig = MAC;
        end
      end
      MAC: begin
        mac_en  = 1'b1;
        Ocupado = 1'b1;
        if (paso == ULTIMO_PASO) begin
          estado_sig = SATURA;
        end
      end
      SATURA: begin
        Ocupado    = 1'b1;
        estado_sig = REPOSO;
      end
      default: begin
        estado_sig = REPOSO;
      end
    endcase
  end

  // Step counter selecting which of the five products is applied; it sits
  // at zero outside MAC so every sample starts with b0.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      paso <= '0;
    end else if (estado == MAC) begin
      paso <= paso + 3'd1;
    end else begin
      paso <= '0;
    end
  end

  // Latch the sample and its channel when accepted so the input bus is free
  // to change during the computation.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      x_cur     <= '0;
      canal_cur <= '0;
    end else if (acepta) begin
      x_cur     <= Uk;
      canal_cur <= Canal_In;
    end
  end

  // Coefficient bank shared by all channels. Writes only land while idle and
  // not on the edge a sample is taken, so a computation never sees a mix of
  // old and new coefficients. Reset leaves a unity-gain passthrough.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      for (int i = 0; i < NUM_COEF; i++) begin
        coef[i] <= '0;
      end
      coef[COEF_B0] <= COEF_UNO;
    end else if (Coef_We && (estado == REPOSO) && !acepta &&
                 (Coef_Addr <= COEF_A2)) begin
      coef[Coef_Addr] <= Coef_Data;
    end
  end

  // Operand/coefficient selection for the single multiplier, in the order
  // b0*x, b1*x1, b2*x2, a1*y1, a2*y2; the last two are subtracted.
  always_comb begin
    coef_sel = '0;
    operando = '0;
    restar   = 1'b0;
    case (paso)
      3'd0: begin
        coef_sel = coef[COEF_B0];
        operando = x_cur;
      end
      3'd1: begin
        coef_sel = coef[COEF_B1];
        operando = x1_mem[canal_cur];
      end
      3'd2: begin
        coef_sel = coef[COEF_B2];
        operando = x2_mem[canal_cur];
      end
      3'd3: begin
        coef_sel = coef[COEF_A1];
        operando = y1_mem[canal_cur];
        restar   = 1'b1;
      end
      3'd4: begin
        coef_sel = coef[COEF_A2];
        operando = y2_mem[canal_cur];
        restar   = 1'b1;
      end
      default: begin
        coef_sel = '0;
        operando = '0;
        restar   = 1'b0;
      end
    endcase
  end

  filtro_mac_sat #(
    .N (N),
    .F (F)
  ) u_mac_sat (
    .clk      (Clk),
    .reset_n  (Reset_n),
    .clear    (acepta),
    .enable   (mac_en),
    .subtract (restar),
    .coef     (coef_sel),
    .operand  (operando),
    .y_sat    (y_sat),
    .saturado (sat)
  );

  // Per-channel delay lines shift only when a sample completes, so an
  // aborted sample leaves its channel untouched. The clipped value is what
  // feeds back, keeping the recursion inside the N-bit range.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      for (int i = 0; i < CANALES; i++) begin
        x1_mem[i] <= '0;
        x2_mem[i] <= '0;
        y1_mem[i] <= '0;
        y2_mem[i] <= '0;
      end
    end else if (estado == SATURA) begin
      x2_mem[canal_cur] <= x1_mem[canal_cur];
      x1_mem[canal_cur] <= x_cur;
      y2_mem[canal_cur] <= y1_mem[canal_cur];
      y1_mem[canal_cur] <= y_sat;
    end
  end

  // Result registers: refreshed once per completed sample and held until
  // the next one, with a single-cycle ready pulse alongside.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      Yk            <= '0;
      Canal_Out     <= '0;
      Saturado      <= 1'b0;
      Bandera_Listo <= 1'b0;
    end else begin
      Bandera_Listo <= (estado == SATURA);
      if (estado == SATURA) begin
        Yk        <= y_sat;
        Canal_Out <= canal_cur;
        Saturado  <= sat;
      end
    end
  end

endmodule

// File: tb/tb_filtro_iir_parametrizable.sv
// -----------------------------------------------------------------------------
// tb_filtro_iir_parametrizable
// Self-checking bench for filtro_iir_parametrizable (N=25, F=15, CANALES=2).
// A behavioural model evaluates the difference equation with 64-bit integer
// arithmetic per channel; directed cases cover the documented examples and a
// randomized phase mixes samples, channels and coefficient writes.
// -----------------------------------------------------------------------------
module tb_filtro_iir_parametrizable;

  localparam int N       = 25;
  localparam int F       = 15;
  localparam int CANALES = 2;
  localparam int CW      = 1;

  localparam longint Y_MAX = (longint'(1) << (N-1)) - 1;
  localparam longint Y_MIN = -(longint'(1) << (N-1));

  logic                Clk;
  logic                Reset_n;
  logic signed [N-1:0] Uk;
  logic [CW-1:0]       Canal_In;
  logic                Bandera_ADC;
  logic                Coef_We;
  logic [2:0]          Coef_Addr;
  logic signed [N-1:0] Coef_Data;
  logic signed [N-1:0] Yk;
  logic [CW-1:0]       Canal_Out;
  logic                Bandera_Listo;
  logic                Saturado;
  logic                Ocupado;

  int testsRun    = 0;
  int testsFailed = 0;

  longint coefM [5];
  longint xh1 [CANALES];
  longint xh2 [CANALES];
  longint yh1 [CANALES];
  longint yh2 [CANALES];
  longint lastY;
  longint lastSat;
  longint lastCanal;

  filtro_iir_parametrizable #(
    .N       (N),
    .F       (F),
    .CANALES (CANALES)
  ) dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .Uk            (Uk),
    .Canal_In      (Canal_In),
    .Bandera_ADC   (Bandera_ADC),
    .Coef_We       (Coef_We),
    .Coef_Addr     (Coef_Addr),
    .Coef_Data     (Coef_Data),
    .Yk            (Yk),
    .Canal_Out     (Canal_Out),
    .Bandera_Listo (Bandera_Listo),
    .Saturado      (Saturado),
    .Ocupado       (Ocupado)
  );

  // Free-running 10 ns clock.
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Reference state after reset: passthrough coefficients, empty histories.
  function automatic void modelReset();
    coefM[0] = longint'(1) << F;
    for (int i = 1; i < 5; i++) coefM[i] = 0;
    for (int c = 0; c < CANALES; c++) begin
      xh1[c] = 0;
      xh2[c] = 0;
      yh1[c] = 0;
      yh2[c] = 0;
    end
    lastY     = 0;
    lastSat   = 0;
    lastCanal = 0;
  endfunction

  // Difference equation evaluated exactly, floored by F bits, then clipped.
  function automatic void modelStep(input int c, input longint x, output longint y, output longint s);
    longint acc;
    longint sh;
    acc = coefM[0] * x + coefM[1] * xh1[c] + coefM[2] * xh2[c]
        - coefM[3] * yh1[c] - coefM[4] * yh2[c];
    sh = acc >>> F;
    s  = 0;
    y  = sh;
    if (sh > Y_MAX) begin
      y = Y_MAX;
      s = 1;
    end else if (sh < Y_MIN) begin
      y = Y_MIN;
      s = 1;
    end
    xh2[c] = xh1[c];
    xh1[c] = x;
    yh2[c] = yh1[c];
    yh1[c] = y;
  endfunction

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_yk"}, Yk, 0);
    checkOutput({tag, "_canal"}, Canal_Out, 0);
    checkOutput({tag, "_listo"}, Bandera_Listo, 0);
    checkOutput({tag, "_sat"}, Saturado, 0);
    checkOutput({tag, "_ocupado"}, Ocupado, 0);
  endtask

  task automatic doReset();
    Reset_n = 1'b0;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    modelReset();
  endtask

  task automatic idleCycle();
    @(posedge Clk); #1;
    checkOutput("listo_idle", Bandera_Listo, 0);
    checkOutput("ocupado_idle", Ocupado, 0);
    checkOutput("yk_idle_hold", Yk, lastY);
  endtask

  task automatic writeCoef(input int addr, input longint value);
    Coef_We   = 1'b1;
    Coef_Addr = addr[2:0];
    Coef_Data = value[N-1:0];
    @(posedge Clk); #1;
    Coef_We = 1'b0;
    if (addr < 5) coefM[addr] = value;
  endtask

  // Present one sample in the current cycle k and follow it to k+7.
  // mode 0: plain; mode 1: extra strobe + b0 write in k+3 (must be dropped);
  // mode 2: reset pulse in k+3 (sample must be abandoned).
  task automatic applyStimulus(input int canal, input longint uk, input int mode, output longint yOut);
    longint expY;
    longint expSat;
    expY   = 0;
    expSat = 0;
    Uk          = uk[N-1:0];
    Canal_In    = canal[CW-1:0];
    Bandera_ADC = 1'b1;
    @(posedge Clk); #1;
    Bandera_ADC = 1'b0;
    Uk          = N'($urandom);
    if (mode != 2) modelStep(canal, uk, expY, expSat);
    for (int c = 1; c <= 6; c++) begin
      checkOutput("ocupado_busy", Ocupado, 1);
      checkOutput("listo_early", Bandera_Listo, 0);
      checkOutput("yk_hold", Yk, lastY);
      checkOutput("sat_hold", Saturado, lastSat);
      if (c == 3 && mode == 1) begin
        Bandera_ADC = 1'b1;
        Canal_In    = canal[CW-1:0];
        Coef_We     = 1'b1;
        Coef_Addr   = 3'd0;
        Coef_Data   = '0;
      end
      if (c == 3 && mode == 2) Reset_n = 1'b0;
      @(posedge Clk); #1;
      Bandera_ADC = 1'b0;
      Coef_We     = 1'b0;
      if (c == 3 && mode == 2) begin
        Reset_n = 1'b1;
        modelReset();
        checkAllZero("abort");
        for (int w = 0; w < 9; w++) begin
          @(posedge Clk); #1;
          checkOutput("abort_no_listo", Bandera_Listo, 0);
        end
        yOut = Yk;
        return;
      end
    end
    checkOutput("listo_k7", Bandera_Listo, 1);
    checkOutput("ocupado_k7", Ocupado, 0);
    checkOutput("yk", Yk, expY);
    checkOutput("saturado", Saturado, expSat);
    checkOutput("canal_out", Canal_Out, canal);
    lastY     = expY;
    lastSat   = expSat;
    lastCanal = canal;
    yOut      = Yk;
    if (mode == 1) idleCycle();
  endtask

  initial begin
    longint y;
    longint u;
    Reset_n     = 1'b0;
    Uk          = '0;
    Canal_In    = '0;
    Bandera_ADC = 1'b0;
    Coef_We     = 1'b0;
    Coef_Addr   = '0;
    Coef_Data   = '0;

    doReset();
    checkAllZero("reset");

    // Passthrough after reset.
    applyStimulus(0, 1000, 0, y);
    checkOutput("pass_1000", y, 1000);

    // FIR half/half impulse response.
    doReset();
    writeCoef(0, 16384);
    writeCoef(1, 16384);
    applyStimulus(0, 32768, 0, y);
    checkOutput("imp_y0", y, 16384);
    applyStimulus(0, 0, 0, y);
    checkOutput("imp_y1", y, 16384);
    applyStimulus(0, 0, 0, y);
    checkOutput("imp_y2", y, 0);

    // First-order recursion on channel 1, channel 0 must stay clean.
    doReset();
    writeCoef(3, -16384);
    writeCoef(0, 32768);
    applyStimulus(1, 1000, 0, y);
    checkOutput("step_y0", y, 1000);
    applyStimulus(1, 1000, 0, y);
    checkOutput("step_y1", y, 1500);
    applyStimulus(1, 1000, 0, y);
    checkOutput("step_y2", y, 1750);
    applyStimulus(0, 200, 0, y);
    checkOutput("ch0_isolated", y, 200);

    // Saturation at both rails.
    doReset();
    writeCoef(0, 16777215);
    applyStimulus(0, 16777215, 0, y);
    checkOutput("sat_pos", y, 16777215);
    checkOutput("sat_pos_flag", Saturado, 1);
    applyStimulus(0, -16777216, 0, y);
    checkOutput("sat_neg", y, -16777216);
    checkOutput("sat_neg_flag", Saturado, 1);

    // Strobe and coefficient write while busy are both discarded.
    doReset();
    applyStimulus(0, 700, 1, y);
    checkOutput("drop_y", y, 700);
    applyStimulus(0, 300, 0, y);
    checkOutput("b0_kept", y, 300);

    // Reset mid-computation aborts; the block then works normally.
    doReset();
    applyStimulus(0, 1234, 2, y);
    applyStimulus(0, 500, 0, y);
    checkOutput("after_abort", y, 500);

    // Randomized mix of coefficient writes, channels and sample values.
    doReset();
    for (int it = 0; it < 150; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        writeCoef(int'($urandom_range(0, 7)), longint'($urandom_range(0, 131072)) - 65536);
      end
      if ($urandom_range(0, 9) == 0) begin
        u = longint'($urandom_range(0, 33554431)) + Y_MIN;
      end else begin
        u = longint'($urandom_range(0, 4000)) - 2000;
      end
      applyStimulus(int'($urandom_range(0, CANALES-1)), u,
                    ($urandom_range(0, 9) == 0) ? 1 : 0, y);
      repeat ($urandom_range(0, 2)) idleCycle();
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
